// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and shared memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if;
  // instruction fetch requester
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  // MEM-stage data requester
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [7:0]  dm_wstrb;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  // shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  // hazard unit stalls
  logic        stall_if;
  logic        stall_m;

  // arbiter side
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output dm_rdata, dm_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output stall_if, stall_m
  );

  // pipeline and memory side
  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  dm_rdata, dm_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  stall_if, stall_m
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and data
module mem_port_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  state_t      state_q;
  logic        owner_dm_q;    // 1 = data transaction, 0 = fetch
  logic        kill_q;        // current fetch was flushed; swallow its completion
  logic        done_q;        // a transaction completed last cycle; hold off arbitration
  logic [2:0]  starve_cnt_q;
  logic        sel_hi_q;      // fetch word lives in the upper half of the doubleword

  logic        mem_req_q;
  logic        mem_we_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [7:0]  mem_wstrb_q;

  logic [31:0] if_rdata_q;
  logic        if_valid_q;
  logic [63:0] dm_rdata_q;
  logic        dm_valid_q;

  logic        arb_en;
  logic        starved;
  logic        grant_dm;
  logic        grant_if;
  logic        busy_fetch;
  logic [2:0]  starve_cnt_d;
  logic        kill_d;

  // Address bits below the doubleword are not needed: the port is doubleword-wide
  // and fetch only needs bit 2 to pick its half.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.dm_addr[2:0]};

  // Arbitration decision, starvation counter and kill flag next-state
  always_comb begin
    arb_en       = (state_q == IDLE) && !done_q;
    starved      = (starve_cnt_q == STARVE_LIMIT) && bus.if_req;
    grant_dm     = arb_en && bus.dm_req && !starved;
    grant_if     = arb_en && bus.if_req && !grant_dm;
    busy_fetch   = (state_q != IDLE) && !owner_dm_q;

    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || grant_if) begin
      starve_cnt_d = 3'd0;
    end else if (grant_dm && (starve_cnt_q != STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end

    // a flush in the same cycle as the response still suppresses that response
    kill_d = kill_q;
    if (busy_fetch && bus.if_flush) begin
      kill_d = 1'b1;
    end
  end

  // Transaction FSM with registered port and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_dm_q   <= 1'b0;
      kill_q       <= 1'b0;
      done_q       <= 1'b0;
      starve_cnt_q <= 3'd0;
      sel_hi_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
      mem_wstrb_q  <= 8'd0;
      if_rdata_q   <= 32'd0;
      if_valid_q   <= 1'b0;
      dm_rdata_q   <= 64'd0;
      dm_valid_q   <= 1'b0;
    end else begin
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      starve_cnt_q <= starve_cnt_d;
      kill_q       <= kill_d;

      case (state_q)
        IDLE: begin
          if (grant_dm) begin
            owner_dm_q  <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= {bus.dm_addr[63:3], 3'b000};
            mem_wdata_q <= bus.dm_wdata;
            mem_wstrb_q <= bus.dm_wstrb;
            mem_req_q   <= 1'b1;
            state_q     <= WAIT_GNT;
          end else if (grant_if) begin
            owner_dm_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {bus.if_addr[63:3], 3'b000};
            mem_wdata_q <= 64'd0;
            mem_wstrb_q <= 8'd0;
            sel_hi_q    <= bus.if_addr[2];
            mem_req_q   <= 1'b1;
            state_q     <= WAIT_GNT;
          end
        end

        WAIT_GNT: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          if (bus.mem_rvalid) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            kill_q  <= 1'b0;
            if (owner_dm_q) begin
              dm_rdata_q <= bus.mem_rdata;
              dm_valid_q <= 1'b1;
            end else if (!kill_d) begin
              if_rdata_q <= sel_hi_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
              if_valid_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;

  // hazard stalls follow the live requests so a new request stalls immediately
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_m   = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; registered outputs are stable on return
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // wait (bounded) for mem_req, grant it, then respond; returns in the valid cycle
  task automatic serve(input logic [63:0] rd, output logic ok, output logic [63:0] addr,
                       output logic we, output logic [7:0] wstrb);
    ok = 1'b0;
    addr = 64'd0;
    we = 1'b0;
    wstrb = 8'd0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req === 1'b1) break;
      step();
    end
    if (bus.mem_req === 1'b1) begin
      ok = 1'b1;
      addr = bus.mem_addr;
      we = bus.mem_we;
      wstrb = bus.mem_wstrb;
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = rd;
      step();
      bus.mem_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.mem_req, bus.if_valid, bus.dm_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got req/ifv/dmv=%b expected 000", {bus.mem_req, bus.if_valid, bus.dm_valid});
    end
    checks++;
    if ({bus.if_rdata, bus.dm_rdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: got if_rdata=%h dm_rdata=%h expected 0", bus.if_rdata, bus.dm_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    bus.if_req = 1'b1;
    bus.if_addr = 64'h104;
    #1;
    checks++;
    if (bus.stall_if !== 1'b1) begin errors++; $display("FAIL sf_stall_c0: got %b expected 1", bus.stall_if); end
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h100 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 8'h00) begin
      errors++;
      $display("FAIL sf_c1_port: got req=%b addr=%h we=%b wstrb=%h expected 1 100 0 00", bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wstrb);
    end
    checks++;
    if (bus.stall_if !== 1'b1) begin errors++; $display("FAIL sf_stall_c1: got %b expected 1", bus.stall_if); end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.stall_if !== 1'b1) begin
      errors++;
      $display("FAIL sf_c2: got req=%b stall_if=%b expected 0 1", bus.mem_req, bus.stall_if);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 64'hAAAA_BBBB_1111_2222;
    step();
    bus.mem_rvalid = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hAAAABBBB || bus.stall_if !== 1'b0) begin
      errors++;
      $display("FAIL sf_c3_valid: got v=%b data=%h stall=%b expected 1 aaaabbbb 0", bus.if_valid, bus.if_rdata, bus.stall_if);
    end
    bus.if_req = 1'b0;
    step();
    checks++;
    if (bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL sf_c4_no_regrant: got v=%b req=%b expected 0 0", bus.if_valid, bus.mem_req);
    end
  endtask

  task automatic test_priority();
    logic ok; logic [63:0] a; logic w; logic [7:0] s;
    bus.if_req = 1'b1;
    bus.if_addr = 64'h200;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b1;
    bus.dm_addr = 64'h2008;
    bus.dm_wdata = 64'h0123_4567_89AB_CDEF;
    bus.dm_wstrb = 8'hFF;
    serve(64'h0, ok, a, w, s);
    checks++;
    if (ok !== 1'b1 || a !== 64'h2008 || w !== 1'b1 || s !== 8'hFF) begin
      errors++;
      $display("FAIL pri_first_data: got ok=%b addr=%h we=%b wstrb=%h expected 1 2008 1 ff", ok, a, w, s);
    end
    checks++;
    if (bus.dm_valid !== 1'b1 || bus.stall_if !== 1'b1 || bus.stall_m !== 1'b0) begin
      errors++;
      $display("FAIL pri_dm_valid: got dmv=%b stall_if=%b stall_m=%b expected 1 1 0", bus.dm_valid, bus.stall_if, bus.stall_m);
    end
    bus.dm_req = 1'b0;
    serve(64'hCAFE_F00D_1234_5678, ok, a, w, s);
    checks++;
    if (ok !== 1'b1 || a !== 64'h200 || w !== 1'b0 || s !== 8'h00) begin
      errors++;
      $display("FAIL pri_then_fetch: got ok=%b addr=%h we=%b wstrb=%h expected 1 200 0 00", ok, a, w, s);
    end
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL pri_fetch_data: got v=%b data=%h expected 1 12345678", bus.if_valid, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic ok; logic [63:0] a; logic w; logic [7:0] s;
    logic [63:0] exp_a;
    bus.if_req = 1'b1;
    bus.if_addr = 64'h300;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_addr = 64'h1000;
    bus.dm_wstrb = 8'h00;
    for (int g = 0; g < 6; g++) begin
      exp_a = (g == 4) ? 64'h300 : 64'h1000;
      serve(64'h1111_2222_3333_4444 + 64'(g), ok, a, w, s);
      checks++;
      if (ok !== 1'b1 || a !== exp_a) begin
        errors++;
        $display("FAIL starve_grant%0d: got ok=%b addr=%h expected 1 %h", g, ok, a, exp_a);
      end
      checks++;
      if (bus.dm_valid !== (g != 4) || bus.if_valid !== (g == 4)) begin
        errors++;
        $display("FAIL starve_valid%0d: got dmv=%b ifv=%b expected %b %b", g, bus.dm_valid, bus.if_valid, g != 4, g == 4);
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_flush();
    logic ok; logic [63:0] a; logic w; logic [7:0] s;
    bus.if_req = 1'b1;
    bus.if_addr = 64'h400;
    step();
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fl_req: got %b expected 1", bus.mem_req); end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    bus.mem_rvalid = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fl_suppressed: got v=%b req=%b expected 0 0", bus.if_valid, bus.mem_req);
    end
    bus.if_addr = 64'h40C;
    serve(64'h5555_6666_7777_8888, ok, a, w, s);
    checks++;
    if (ok !== 1'b1 || a !== 64'h408) begin
      errors++;
      $display("FAIL fl_next_addr: got ok=%b addr=%h expected 1 408", ok, a);
    end
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h55556666) begin
      errors++;
      $display("FAIL fl_next_valid: got v=%b data=%h expected 1 55556666", bus.if_valid, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_gnt_stall();
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b1;
    bus.dm_addr = 64'h5013;
    bus.dm_wdata = 64'hFEED_FACE_0BAD_F00D;
    bus.dm_wstrb = 8'h0F;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h5010 || bus.mem_wdata !== 64'hFEED_FACE_0BAD_F00D ||
          bus.mem_wstrb !== 8'h0F || bus.mem_we !== 1'b1 || bus.stall_m !== 1'b1) begin
        errors++;
        $display("FAIL gs_hold%0d: got req=%b addr=%h wd=%h ws=%h we=%b stall_m=%b expected 1 5010 feedface0badf00d 0f 1 1",
                 c, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_we, bus.stall_m);
      end
      step();
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    checks++;
    if (bus.stall_m !== 1'b1) begin errors++; $display("FAIL gs_stall_resp: got %b expected 1", bus.stall_m); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 64'h0000_0000_0000_ACED;
    step();
    bus.mem_rvalid = 1'b0;
    checks++;
    if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== 64'hACED || bus.stall_m !== 1'b0) begin
      errors++;
      $display("FAIL gs_done: got v=%b data=%h stall_m=%b expected 1 aced 0", bus.dm_valid, bus.dm_rdata, bus.stall_m);
    end
    bus.dm_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_addr = 64'h3000;
    step();
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rm_req: got %b expected 1", bus.mem_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.dm_req = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rm_req_drop: got %b expected 0", bus.mem_req); end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 64'h9999_8888_7777_6666;
    step();
    bus.mem_rvalid = 1'b0;
    checks++;
    if ({bus.mem_req, bus.if_valid, bus.dm_valid} !== 3'b000 || bus.dm_rdata !== 64'd0 || bus.if_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rm_ignored: got req/ifv/dmv=%b dm_rdata=%h if_rdata=%h expected 000 0 0",
               {bus.mem_req, bus.if_valid, bus.dm_valid}, bus.dm_rdata, bus.if_rdata);
    end
    step();
    checks++;
    if ({bus.mem_req, bus.if_valid, bus.dm_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rm_quiet: got %b expected 000", {bus.mem_req, bus.if_valid, bus.dm_valid});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = 64'd0;
    bus.if_flush = 1'b0;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    bus.dm_addr = 64'd0;
    bus.dm_wdata = 64'd0;
    bus.dm_wstrb = 8'd0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 64'd0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_flush();
    test_gnt_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning); clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch requests instruction read; held until if_valid.
- if_addr  in  64  fetch byte address, word-aligned.
- if_flush  in  1  driven from hazard Flush_D/PCSrc_E; kills in-flight fetch.
- if_rdata  out  32  instruction word.
- if_valid  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  MEM stage load/store request; held until dm_valid.
- dm_we  in  1  1 = store.
- dm_addr  in  64  data byte address.
- dm_wdata  in  64  store data.
- dm_wstrb  in  8  byte enables.
- dm_rdata  out  64  load data.
- dm_valid  out  1  one-cycle data completion pulse.
- mem_req  out  1  shared-port request.
- mem_we  out  1  shared-port write enable.
- mem_addr  out  64  shared-port address, doubleword-aligned (bits [2:0] = 0).
- mem_wdata  out  64  shared-port write data.
- mem_wstrb  out  8  shared-port byte enables.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response (read data or write ack).
- mem_rdata  in  64  response data.
- stall_if  out  1  fetch stall into hazard logic.
- stall_m  out  1  MEM-stage stall into hazard logic.
REQ-002 Clock SHALL be clk; reset SHALL be rst, synchronous, active-high.

Function
REQ-003 The arbiter SHALL keep at most one memory transaction outstanding.
REQ-004 FSM states SHALL be IDLE, WAIT_GNT and WAIT_RESP.
- IDLE -> WAIT_GNT when any request is pending.
- WAIT_GNT -> WAIT_RESP on mem_gnt.
- WAIT_RESP -> IDLE on mem_rvalid.
REQ-005 In IDLE the arbiter SHALL grant dm_req over if_req, except when the starvation counter equals 4 and if_req=1, in which case it grants fetch.
REQ-006 Starvation counter (3-bit):
- SHALL increment on each data grant made while if_req=1.
- SHALL clear on a fetch grant or on any cycle with if_req=0.
- SHALL saturate at 4.
REQ-007 On grant, owner, we, address, wdata and wstrb SHALL be registered. mem_addr SHALL be {addr[63:3],3'b000}. For fetch grants, mem_we=0 and mem_wstrb=0.
REQ-008 mem_req SHALL be 1 exactly in WAIT_GNT. mem_addr, mem_we, mem_wdata and mem_wstrb SHALL be stable while mem_req=1.
REQ-009 On mem_rvalid in WAIT_RESP, the arbiter SHALL register the response. The owner's valid SHALL pulse for exactly one cycle on the next cycle.
- Fetch: if_rdata = if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
- Data: dm_rdata = mem_rdata.
- Data outputs SHALL hold their value until the next completion.
REQ-010 Minimum latency from request to valid SHALL be 3 cycles (gnt in cycle 1, rvalid in cycle 2, valid in cycle 3).
REQ-011 if_flush while a fetch is in WAIT_GNT or WAIT_RESP SHALL set a kill flag.
- The transaction SHALL still complete on the port.
- if_valid SHALL be suppressed for that transaction.
- The kill flag SHALL clear on that transaction's completion.
REQ-012 if_flush in IDLE, or during a data transaction, SHALL have no effect.
REQ-013 stall_if SHALL equal if_req & ~if_valid. stall_m SHALL equal dm_req & ~dm_valid. Both are combinational.
REQ-014 mem_rvalid in IDLE or WAIT_GNT SHALL be ignored.
REQ-015 if_req or dm_req deasserted mid-transaction SHALL NOT abort the transaction.
REQ-016 A new arbitration SHALL occur in IDLE no earlier than the cycle after a valid pulse, so a requester that drops its req on valid is not re-granted.

Reset
REQ-017 While rst=1, the block SHALL:
- set the state to IDLE;
- clear the counter and kill flag;
- drive mem_req, if_valid and dm_valid to 0;
- drive if_rdata and dm_rdata to 0.
REQ-018 Reset mid-transaction SHALL drop mem_req on the next cycle. Any later mem_rvalid for the abandoned transaction SHALL be ignored.

Verification
REQ-019 Single fetch: if_req=1, if_addr=0x104; mem_gnt in cycle 1; mem_rvalid in cycle 2 with mem_rdata=0xAAAA_BBBB_1111_2222.
- Expect mem_addr=0x100.
- Expect if_valid in cycle 3 with if_rdata=0xAAAABBBB.
- Expect stall_if=1 in cycles 0-2.
REQ-020 Simultaneous if_req and dm_req (store, dm_addr=0x2008, wstrb=0xFF): data is granted first; fetch completes after dm_valid; stall_if stays high throughout.
REQ-021 Starvation: dm_req stays high with back-to-back loads while if_req=1. After 4 data grants the 5th grant goes to fetch, then data resumes.
REQ-022 Flush: assert if_flush during WAIT_RESP of a fetch. Expect no if_valid; the port completes normally; the next fetch after IDLE completes with if_valid.
REQ-023 Reset: assert rst in WAIT_GNT. Expect mem_req=0 the next cycle; a mem_rvalid two cycles later produces no valid pulse; all outputs are 0.
REQ-024 Gnt stall: hold mem_gnt=0 for 5 cycles. mem_req and mem_addr stay stable and stall_m stays 1 until dm_valid.
